encoder_menu_ctrl: RTL and testbench

- Menu/parameter controller that sits downstream of the rotational encoder front end.
- Consumes the 4-bit encoder count and the 2-bit press-type code, then sequences a browse/edit/lock state machine over a bank of NUM_SLOTS parameter registers.
- Drives the committed parameter values, the selected index and the current mode to the rest of the design.

---
 rtl/encoder_menu_ctrl.sv | 101 ++++++++++
 tb/tb_encoder_menu_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_menu_ctrl.sv
// encoder_menu_ctrl: browse/edit/lock menu controller over a bank of encoder-edited parameter registers
module encoder_menu_ctrl #(
    parameter int NUM_SLOTS   = 4,
    parameter int VAL_W       = 8,
    parameter int VAL_MAX     = 255,
    parameter int DEFAULT_VAL = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   enc,
    input  logic [1:0]                   pb_press_type,
    output logic [NUM_SLOTS*VAL_W-1:0]   param_bus,
    output logic [$clog2(NUM_SLOTS)-1:0] sel,
    output logic [VAL_W-1:0]             edit_val,
    output logic [1:0]                   mode,
    output logic                         commit,
    output logic [$clog2(NUM_SLOTS)-1:0] commit_idx
);
    localparam int SEL_W = $clog2(NUM_SLOTS);
    typedef enum logic [1:0] {BROWSE = 2'b00, EDIT = 2'b01, LOCKED = 2'b10} state_t;
    state_t                     state, state_n;
    logic [NUM_SLOTS*VAL_W-1:0] bus_n;
    logic [SEL_W-1:0]           sel_n, cidx_n;
    logic [VAL_W-1:0]           edit_n, cur, clamped;
    logic                       commit_n, press, sup, pos, neg;
    logic [3:0]                 enc_prev;
    logic signed [3:0]          delta;
    logic signed [VAL_W+1:0]    sum;
    assign mode = state;
    always_comb begin
        press   = pb_press_type != 2'b00;
        delta   = (press || sup) ? 4'sd0 : $signed(enc - enc_prev);
        pos     = !delta[3] && (delta != 4'sd0);
        neg     = delta[3];
        cur     = param_bus[sel*VAL_W +: VAL_W];
        sum     = $signed({2'b00, edit_val}) + {{(VAL_W-2){delta[3]}}, delta};
        clamped = sum[VAL_W+1] ? '0 : (sum > (VAL_W+2)'(VAL_MAX)) ? VAL_W'(VAL_MAX) : sum[VAL_W-1:0];
        state_n  = state;
        bus_n    = param_bus;
        sel_n    = sel;
        edit_n   = edit_val;
        commit_n = 1'b0;
        cidx_n   = commit_idx;
        case (state)
            BROWSE: begin
                if (press) begin
                    case (pb_press_type)
                        2'b01: begin
                            edit_n  = cur;
                            state_n = EDIT;
                        end
                        2'b11: state_n = LOCKED;
                        default: ;
                    endcase
                end else begin
                    sel_n = pos ? sel + 1'b1 : neg ? sel - 1'b1 : sel;
                end
            end
            EDIT: begin
                if (press) begin
                    case (pb_press_type)
                        2'b01: begin
                            bus_n[sel*VAL_W +: VAL_W] = edit_val;
                            commit_n = 1'b1;
                            cidx_n   = sel;
                            state_n  = BROWSE;
                        end
                        2'b10: state_n = BROWSE;
                        2'b11: edit_n = VAL_W'(DEFAULT_VAL);
                        default: ;
                    endcase
                end else begin
                    edit_n = (pos || neg) ? clamped : edit_val;
                end
            end
            LOCKED: state_n = (pb_press_type == 2'b11) ? BROWSE : LOCKED;
            default: state_n = BROWSE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BROWSE;
            param_bus  <= {NUM_SLOTS{VAL_W'(DEFAULT_VAL)}};
            sel        <= '0;
            edit_val   <= '0;
            commit     <= 1'b0;
            commit_idx <= '0;
            enc_prev   <= 4'd8;
            sup        <= 1'b0;
        end else begin
            state      <= state_n;
            param_bus  <= bus_n;
            sel        <= sel_n;
            edit_val   <= edit_n;
            commit     <= commit_n;
            commit_idx <= cidx_n;
            enc_prev   <= enc;
            sup        <= press;
        end
    end
endmodule

// File: tb/tb_encoder_menu_ctrl.sv
// tb_encoder_menu_ctrl: directed stimulus, cycle-by-cycle reference model plus literal spot checks
module tb_encoder_menu_ctrl;
    localparam int N = 4;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   enc = 4'd8;
    logic [1:0]   pb = 2'b00;
    logic [N*W-1:0] param_bus;
    logic [1:0]   sel, commit_idx, mode;
    logic [W-1:0] edit_val;
    logic         commit;
    int npass = 0, ntot = 0;
    bit chk_en = 0;
    int m_slot[N];
    int m_sel, m_edit, m_mode, m_commit, m_cidx, m_prev, m_sup, d;
    bit pr;

    encoder_menu_ctrl #(.NUM_SLOTS(N), .VAL_W(W), .VAL_MAX(255), .DEFAULT_VAL(128)) dut (
        .clk(clk), .rst(rst), .enc(enc), .pb_press_type(pb), .param_bus(param_bus),
        .sel(sel), .edit_val(edit_val), .mode(mode), .commit(commit), .commit_idx(commit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: menu rules in plain integer arithmetic
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_slot[i] = 128;
            m_sel = 0; m_edit = 0; m_mode = 0; m_commit = 0; m_cidx = 0; m_prev = 8; m_sup = 0;
        end else begin
            pr = pb != 2'b00;
            d = (pr || m_sup) ? 0 : ((int'(enc) - m_prev + 24) % 16) - 8;
            m_prev = int'(enc);
            m_sup = pr;
            m_commit = 0;
            if (m_mode == 0) begin
                if (pb == 2'd1) begin m_edit = m_slot[m_sel]; m_mode = 1; end
                else if (pb == 2'd3) m_mode = 2;
                else if (!pr && d > 0) m_sel = (m_sel + 1) % N;
                else if (!pr && d < 0) m_sel = (m_sel + N - 1) % N;
            end else if (m_mode == 1) begin
                if (pb == 2'd1) begin m_slot[m_sel] = m_edit; m_commit = 1; m_cidx = m_sel; m_mode = 0; end
                else if (pb == 2'd2) m_mode = 0;
                else if (pb == 2'd3) m_edit = 128;
                else m_edit = (m_edit + d > 255) ? 255 : (m_edit + d < 0) ? 0 : m_edit + d;
            end else if (pb == 2'd3) m_mode = 0;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("sel", 32'(sel), 32'(m_sel));
        check("edit_val", 32'(edit_val), 32'(m_edit));
        check("mode", 32'(mode), 32'(m_mode));
        check("commit", 32'(commit), 32'(m_commit));
        check("commit_idx", 32'(commit_idx), 32'(m_cidx));
        for (int i = 0; i < N; i++) check("slot", 32'(param_bus[i*W +: W]), 32'(m_slot[i]));
    end

    task automatic cyc(input logic [3:0] e, input logic [1:0] p);
        enc = e;
        pb = p;
        @(posedge clk);
        #1;
    endtask

    task automatic turn(input int s);
        cyc(4'(int'(enc) + s), 2'b00);
    endtask

    task automatic press(input logic [1:0] p);
        cyc(enc, p);
        cyc(4'd8, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        cyc(4'd8, 2'b00);
        chk_en = 1;
        cyc(4'd8, 2'b00);
        rst = 1'b0;
        check("rst_bus", param_bus, 32'h80808080);
        check("rst_sel", 32'(sel), 0);
        check("rst_mode", 32'(mode), 0);
        check("rst_edit", 32'(edit_val), 0);
        for (int i = 0; i < 3; i++) turn(1);
        check("t1_sel3", 32'(sel), 3);
        turn(1);
        check("t1_wrap", 32'(sel), 0);
        turn(-1);
        check("t1_wrap_down", 32'(sel), 3);
        turn(5); turn(1); turn(1);
        check("t1_sel2", 32'(sel), 2);
        check("t1_bus", param_bus, 32'h80808080);
        // edit slot 2 to 0x84
        cyc(enc, 2'b01);
        check("t2_mode_edit", 32'(mode), 1);
        check("t2_load", 32'(edit_val), 8'h80);
        cyc(4'd8, 2'b00);
        cyc(4'd12, 2'b00);
        check("t2_edit84", 32'(edit_val), 8'h84);
        cyc(enc, 2'b01);
        check("t2_commit", 32'(commit), 1);
        check("t2_cidx", 32'(commit_idx), 2);
        check("t2_bus", param_bus, 32'h80848080);
        check("t2_mode", 32'(mode), 0);
        cyc(4'd8, 2'b00);
        check("t2_commit_off", 32'(commit), 0);
        // build slot0 = 250, then saturate high
        turn(-1); turn(-1);
        press(2'b01);
        for (int i = 0; i < 17; i++) turn(7);
        turn(3);
        check("t3_250", 32'(edit_val), 250);
        press(2'b01);
        check("t3_slot0", 32'(param_bus[7:0]), 250);
        press(2'b01);
        turn(7);
        check("t3_sat_hi", 32'(edit_val), 255);
        turn(7);
        check("t3_sat_hi2", 32'(edit_val), 255);
        press(2'b10);
        check("t3_cancel_slot0", 32'(param_bus[7:0]), 250);
        // build slot1 = 3, then saturate low
        turn(1);
        press(2'b01);
        for (int i = 0; i < 18; i++) turn(-7);
        turn(1);
        press(2'b01);
        check("t3_slot1", 32'(param_bus[15:8]), 3);
        press(2'b01);
        turn(-7);
        check("t3_sat_lo", 32'(edit_val), 0);
        press(2'b10);
        // long press restores default, normal press cancels
        press(2'b01);
        turn(5);
        check("t4_edit8", 32'(edit_val), 8);
        cyc(enc, 2'b11);
        check("t4_default", 32'(edit_val), 128);
        check("t4_no_commit", 32'(commit), 0);
        check("t4_still_edit", 32'(mode), 1);
        cyc(4'd8, 2'b00);
        press(2'b10);
        check("t4_browse", 32'(mode), 0);
        check("t4_slot1", 32'(param_bus[15:8]), 3);
        // locked mode
        press(2'b11);
        check("t5_locked", 32'(mode), 2);
        turn(2); turn(-3);
        press(2'b01); press(2'b10);
        check("t5_sel_held", 32'(sel), 1);
        check("t5_still_locked", 32'(mode), 2);
        press(2'b11);
        check("t5_unlock", 32'(mode), 0);
        check("t5_sel", 32'(sel), 1);
        // press coincident with encoder jump
        cyc(4'd10, 2'b01);
        check("t6_sel", 32'(sel), 1);
        check("t6_load", 32'(edit_val), 3);
        cyc(4'd8, 2'b00);
        check("t6_edit_masked", 32'(edit_val), 3);
        turn(2);
        check("t6_edit5", 32'(edit_val), 5);
        rst = 1'b1;
        cyc(enc, 2'b00);
        rst = 1'b0;
        check("t6_rst_mode", 32'(mode), 0);
        check("t6_rst_edit", 32'(edit_val), 0);
        check("t6_rst_bus", param_bus, 32'h80808080);
        check("t6_rst_sel", 32'(sel), 0);
        cyc(4'd8, 2'b00);
        @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
